// File: rtl/seq_match_pkg.sv
// Shared types, segment constants and the BCD-to-7-segment decode for seq_match_counter.
// Segments are gfedcba and active-low.
package seq_match_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0   = 7'b1000000;
    localparam seg_t SEG_1   = 7'b1111001;
    localparam seg_t SEG_2   = 7'b0100100;
    localparam seg_t SEG_3   = 7'b0110000;
    localparam seg_t SEG_4   = 7'b0011001;
    localparam seg_t SEG_5   = 7'b0010010;
    localparam seg_t SEG_6   = 7'b0000010;
    localparam seg_t SEG_7   = 7'b1111000;
    localparam seg_t SEG_8   = 7'b0000000;
    localparam seg_t SEG_9   = 7'b0011000;
    localparam seg_t SEG_ERR = 7'b0000111;

    function automatic seg_t bcd_to_seg(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

endpackage

// File: rtl/seq_match_counter_if.sv
// Bundle of control, stream and display signals between the switch/serial side
// (master) and seq_match_counter (slave).
interface seq_match_counter_if #(
    parameter int PAT_W  = 4,
    parameter int DIGITS = 2
);

    logic                  ena;
    logic                  clr;
    logic                  sig_to_test;
    logic [PAT_W-1:0]      pat_in;
    logic [PAT_W-1:0]      mask_in;
    logic                  pat_load;
    logic                  overlap;
    logic                  z;
    logic                  ovf;
    logic [DIGITS*7-1:0]   disp;

    modport master (
        output ena, clr, sig_to_test, pat_in, mask_in, pat_load, overlap,
        input  z, ovf, disp
    );

    modport slave (
        input  ena, clr, sig_to_test, pat_in, mask_in, pat_load, overlap,
        output z, ovf, disp
    );

endinterface

// File: rtl/seq_match_counter_digit.sv
// One BCD digit of the match counter: counts 0..9 on carry_in, ripples carry_out on 9.
module bcd_counter_digit
    import seq_match_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic carry_in,
    output bcd_t digit,
    output logic carry_out
);

    assign carry_out = carry_in & (digit == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (carry_in) begin
            digit <= (digit == 4'd9) ? 4'd0 : bcd_t'(digit + 4'd1);
        end
    end

endmodule

// File: rtl/seq_match_counter.sv
// Programmable serial pattern matcher with BCD match counter and 7-segment outputs.
// SEQMATCH_SATURATE_EN: count holds at all 9s instead of wrapping to all 0s.
module seq_match_counter
    import seq_match_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               DIGITS  = 2,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b0101)
)(
    input  logic              clk,
    input  logic              rst_n,
    seq_match_counter_if.slave bus
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  mask;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic              match;
    logic              inc;
    logic              all_nines;
    logic              near_limit;
    logic              ovf_set;
    logic              ovf_q;
    bcd_t              digits [DIGITS];
    logic              carry  [DIGITS+1];

    assign window = {hist, bus.sig_to_test};
    assign match  = bus.ena & ~bus.clr & ~bus.pat_load & (fill == FILL_FULL)
                  & (((window ^ pattern) & mask) == '0);
    assign bus.z   = match;
    assign bus.ovf = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= PAT_RST;
            mask    <= '1;
            hist    <= '0;
            fill    <= '0;
        end else if (bus.pat_load) begin
            pattern <= bus.pat_in;
            mask    <= bus.mask_in;
            hist    <= '0;
            fill    <= '0;
        end else if (bus.clr) begin
            hist    <= '0;
            fill    <= '0;
        end else if (bus.ena) begin
            // Non-overlap mode drops the matching bit too, so the next window starts fresh.
            if (match && !bus.overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_W-2:0];
                if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
            end
        end
    end

    always_comb begin
        all_nines  = 1'b1;
        near_limit = (digits[0] == 4'd8);
        for (int i = 0; i < DIGITS; i++) begin
            all_nines = all_nines & (digits[i] == 4'd9);
            if (i > 0) near_limit = near_limit & (digits[i] == 4'd9);
        end
    end

`ifdef SEQMATCH_SATURATE_EN
    assign inc     = match & ~all_nines;
    assign ovf_set = (match & (all_nines | near_limit)) | carry[DIGITS];
`else
    assign inc     = match;
    assign ovf_set = carry[DIGITS];
`endif

    assign carry[0] = inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.clr) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_counter_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (bus.clr),
            .carry_in  (carry[g]),
            .digit     (digits[g]),
            .carry_out (carry[g+1])
        );
        assign bus.disp[g*7 +: 7] = bcd_to_seg(digits[g]);
    end

endmodule

// File: tb/tb_seq_match_counter.sv
// Scoreboard bench for seq_match_counter (PAT_W=4, DIGITS=2): directed scenarios plus
// randomized traffic against a queue/integer reference model.
module tb_seq_match_counter;

    typedef struct {
        logic        z;
        logic        ovf;
        logic [13:0] disp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_match_counter_if #(.PAT_W(4), .DIGITS(2)) bus ();

    seq_match_counter #(.PAT_W(4), .DIGITS(2), .PAT_RST(4'b0101)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb [$];
    int          checks = 0;
    int          passed = 0;
    logic [3:0]  mPat;
    logic [3:0]  mMask;
    bit          mHist [$];
    int          mCount;
    logic        mOvf;
    logic [6:0]  segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    function automatic logic [13:0] expDisp(input int c);
        return {segTab[c / 10], segTab[c % 10]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    endtask

    task automatic modelReset();
        mPat   = 4'b0101;
        mMask  = 4'hf;
        mHist.delete();
        mCount = 0;
        mOvf   = 1'b0;
    endtask

    task automatic modelIncrement();
`ifdef SEQMATCH_SATURATE_EN
        if (mCount == 99) begin
            mOvf = 1'b1;
        end else begin
            mCount++;
            if (mCount == 99) mOvf = 1'b1;
        end
`else
        mCount++;
        if (mCount == 100) begin
            mCount = 0;
            mOvf   = 1'b1;
        end
`endif
    endtask

    // Drives one cycle of inputs, queues the expected outputs for it, then advances the model.
    task automatic applyStimulus(input logic e, input logic c, input logic pl, input logic s,
                                 input logic ov, input logic [3:0] pi, input logic [3:0] mi);
        logic [3:0] w;
        logic       zexp;
        @(posedge clk);
        #1;
        bus.ena         = e;
        bus.clr         = c;
        bus.pat_load    = pl;
        bus.sig_to_test = s;
        bus.overlap     = ov;
        bus.pat_in      = pi;
        bus.mask_in     = mi;
        w = 4'b0;
        foreach (mHist[i]) w = {w[2:0], mHist[i]};
        w = {w[2:0], s};
        zexp = e && !c && !pl && (mHist.size() == 3) && (((w ^ mPat) & mMask) == 4'b0);
        sb.push_back('{zexp, mOvf, expDisp(mCount)});
        if (pl) begin
            mPat  = pi;
            mMask = mi;
            mHist.delete();
            if (c) begin
                mCount = 0;
                mOvf   = 1'b0;
            end
        end else if (c) begin
            mCount = 0;
            mOvf   = 1'b0;
            mHist.delete();
        end else if (e) begin
            if (zexp) modelIncrement();
            if (zexp && !ov) begin
                mHist.delete();
            end else begin
                mHist.push_back(s);
                if (mHist.size() > 3) void'(mHist.pop_front());
            end
        end
    endtask

    task automatic streamBits(input logic [5:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, 1'b0, bits[i], ov, 4'h0, 4'h0);
    endtask

    task automatic clearAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("z",    32'(bus.z),    32'(e.z));
            checkOutput("ovf",  32'(bus.ovf),  32'(e.ovf));
            checkOutput("disp", 32'(bus.disp), 32'(e.disp));
        end
    end

    initial begin
        bus.ena = 1'b0; bus.clr = 1'b0; bus.pat_load = 1'b0; bus.sig_to_test = 1'b0;
        bus.overlap = 1'b1; bus.pat_in = 4'h0; bus.mask_in = 4'h0;
        modelReset();
        #12;
        checkOutput("reset_z",    32'(bus.z),    32'd0);
        checkOutput("reset_ovf",  32'(bus.ovf),  32'd0);
        checkOutput("reset_disp", 32'(bus.disp), 32'({7'b1000000, 7'b1000000}));
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern 0101, overlapping: matches on bits 4 and 6.
        streamBits(6'b010101, 6, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        checkOutput("overlap_count", 32'(bus.disp), 32'({7'b1000000, 7'b0100100}));
        clearAll();

        // Non-overlapping: only bit 4 matches.
        streamBits(6'b010101, 6, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("nonoverlap_count", 32'(bus.disp), 32'({7'b1000000, 7'b1111001}));

        // Mid-stream load of 110x.
        streamBits(6'b000011, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b1110);
        streamBits(6'b001101, 4, 1'b0);
        streamBits(6'b001100, 4, 1'b0);
        clearAll();

        // ena low for 5 cycles mid-pattern with the default-equivalent pattern reloaded.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'hf);
        streamBits(6'b000001, 2, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b1, 4'h0, 4'h0);
        streamBits(6'b000001, 2, 1'b1);

        // Counter limit: match-everything mask, 3 fill bits then 100 matches.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 103; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), 1'b1, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        checkOutput("limit_ovf", 32'(bus.ovf), 32'd1);
`ifdef SEQMATCH_SATURATE_EN
        checkOutput("limit_disp", 32'(bus.disp), 32'({7'b0011000, 7'b0011000}));
`else
        checkOutput("limit_disp", 32'(bus.disp), 32'({7'b1000000, 7'b1000000}));
`endif

        // Async reset at count 37 with a live match on the input.
        clearAll();
        for (int i = 0; i < 200 && mCount != 37; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), 1'b1, 4'h0, 4'h0);
        checkOutput("reach_37", 32'(mCount), 32'd37);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_z",    32'(bus.z),    32'd0);
        checkOutput("async_ovf",  32'(bus.ovf),  32'd0);
        checkOutput("async_disp", 32'(bus.disp), 32'({7'b1000000, 7'b1000000}));
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pattern must be back in force.
        streamBits(6'b000101, 4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                          $urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
                          4'($urandom), 4'($urandom & $urandom));

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        checkOutput("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_counter.md
# seq_match_counter

- Parametrised successor to the fixed single-pattern detector.
- Matches a programmable PAT_W-bit serial pattern (optional don't-care mask, overlap or non-overlap mode) on a 1-bit input stream.
- Counts matches in a DIGITS-wide BCD counter and drives one active-low 7-segment display per digit.
- Sits between the board switch/serial input and the seven-segment bank.

## Interface
- PAT_W, default 4: pattern length in bits, 2..16.
- DIGITS, default 2: BCD counter digits and displays, 1..6.
- PAT_RST, default 4'b0101: pattern loaded at reset; bit PAT_W-1 is the oldest bit.
- clk  in  1  main clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  enable; when low, no history shift, no count, no match.
- clr  in  1  synchronous clear of count, ovf and history; pattern kept.
- sig_to_test  in  1  serial bit under test, sampled on each enabled edge.
- pat_in  in  PAT_W  new pattern value.
- mask_in  in  PAT_W  new mask value; 1 = compare, 0 = don't care.
- pat_load  in  1  loads pat_in/mask_in on the next edge and flushes history.
- overlap  in  1  1 = overlapping matches, 0 = history flushed after a match.
- z  out  1  Mealy match flag for the current bit.
- ovf  out  1  sticky flag: counter reached its limit.
- disp  out  DIGITS×7  segments, gfedcba, active-low; digit 0 is the ones digit.

## Operation
- Reset values:
  - pattern = PAT_RST, mask = all ones.
  - history = 0, fill = 0, count = 0, ovf = 0.
  - z = 0; every disp digit = 7'b1000000 ("0").
- History: (PAT_W-1)-bit shift register of past bits plus a fill counter, 0..PAT_W-1.
  - Each enabled edge shifts sig_to_test in and increments fill, saturating at PAT_W-1.
- Window = {history, sig_to_test}, oldest bit in the MSB.
- z = ena & ~clr & ~pat_load & (fill == PAT_W-1) & (((window ^ pattern) & mask) == 0). z is combinational and Mealy.
- On an edge with z = 1:
  - The count increments by 1 in BCD (ripple carry across digits).
  - If overlap = 0, history and fill clear; the current bit is not retained.
- Count limit (10^DIGITS - 1, all 9s): behaviour is set by the Configuration macro. ovf sets on the increment that hits or passes the limit.
- Priority, highest first: rst_n, pat_load, clr, then the normal enabled update.
  - pat_load with clr asserted: pattern loads, and count, ovf and history clear.
- Decode per digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - Any non-BCD value = 0000111.

## Timing
- z is valid in the same cycle as sig_to_test.
- count/ovf update on the edge where z = 1; disp reflects the new count combinationally after that edge (one-cycle latency from the match bit).
- The first possible match is on the PAT_W-th enabled bit after reset, clr, pat_load or a non-overlap flush.
- ena low holds all state; bits present while ena = 0 are ignored.
- Asynchronous reset mid-stream forces all reset values immediately. Release is synchronised by the standard reset bridge upstream.
- Back-to-back matches in consecutive cycles (possible with overlap and a masked pattern) each increment the count.

## Configuration
- SEQMATCH_SATURATE_EN defined:
  - The count holds at all 9s once reached; further matches leave it unchanged.
  - ovf sets on reaching all 9s.
- Not defined:
  - The count wraps from all 9s to all 0s.
  - ovf sets on the wrap; no count update is lost.

## Structure
- Package seq_match_pkg:
  - seg_t (logic [6:0]) and bcd_t (logic [3:0]) typedefs.
  - Segment constants SEG_0..SEG_9 and SEG_ERR.
  - Function bcd_to_seg.
- Sub-module bcd_counter_digit: one BCD digit with carry_in/carry_out and clear; instantiated DIGITS times via generate.
- Top level holds pattern/mask registers, history, fill counter, match compare, saturation/ovf logic and the decode.

## Test plan
- Reset defaults, overlap = 1, stream 0,1,0,1,0,1 → z high on bits 4 and 6; count 2; disp[0] = 0100100, disp[1] = 1000000.
- overlap = 0, same stream → z high on bit 4 only; count 1.
- pat_load with pat_in = 4'b1100, mask_in = 4'b1110 mid-stream; then stream 1,1,0,1 and 1,1,0,0 → both match; count += 2; history flushed on load (no match within 3 bits after load).
- 99 matches with DIGITS = 2, then one more:
  - With SEQMATCH_SATURATE_EN: count 99, ovf = 1.
  - Without: count 00, ovf = 1.
- ena = 0 for 5 cycles mid-pattern → no shift and no z; the pattern completes after ena returns.
- Assert rst_n low asynchronously between edges while count = 37 → disp shows 00, z = 0, ovf = 0 without a clock edge.
